// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared constants for the RV32I multi-cycle control unit: opcode
//            values, FSM state encoding, datapath select encodings and ALU
//            operation codes.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // FSM states; the encoding is visible on state_o for debug
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  // ALU operand A select
  localparam logic [1:0] ALU_SRC_A_PC     = 2'd0;
  localparam logic [1:0] ALU_SRC_A_RS1    = 2'd1;
  localparam logic [1:0] ALU_SRC_A_ZERO   = 2'd2;
  localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'd3;

  // ALU operand B select
  localparam logic [1:0] ALU_SRC_B_RS2    = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU       = 2'd0;
  localparam logic [1:0] PC_SRC_ALU_OUT   = 2'd1;
  localparam logic [1:0] PC_SRC_ALU_LSB0  = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] MEM_TO_REG_ALU   = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM   = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC    = 2'd2;

  // ALU operation requests towards the ALU-control block
  localparam logic [1:0] ALUOP_ADD        = 2'd0;
  localparam logic [1:0] ALUOP_SUB        = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT      = 2'd2;

  // Wait counter width; covers the full 1..255 timeout range
  localparam int WAIT_CNT_W = 8;

  // True for the opcodes that exist only when jump support is built in
  function automatic logic is_jump_class(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts memory wait-state cycles of the current request and flags
//            a timeout when the limit is reached with mem_ready still low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic mem_req,
  input  logic mem_ready,
  output logic timeout
);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  // Wait counter: cleared on every state change, counts stalled request
  // cycles and saturates so a disabled timeout never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // The timeout fires in the stalled cycle whose increment would make the
  // count equal the limit; a mem_ready in that same cycle wins.
  if (MEM_TIMEOUT > 0) begin : g_timeout_on
    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);
    assign timeout = mem_req && !mem_ready && (wait_cnt == LIMIT);
  end else begin : g_timeout_off
    assign timeout = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : RV32I multi-cycle main control FSM. Sequences fetch, decode,
//            execute, memory and writeback, drives datapath selects and a
//            req/ready memory handshake, traps illegal opcodes and memory
//            timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter int ENABLE_JUMP = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         mem_to_reg,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic               mem_fault,
  output logic [3:0]         state_o
);

  localparam bit JUMP_EN = (ENABLE_JUMP != 0);

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op_sel;
  logic       mem_active;
  logic       wait_clear;
  logic       timeout;

  // Request-issuing states, decoded straight from the state register so the
  // timer path does not pass through the main decode block
  assign mem_active = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign wait_clear = (state_next != state);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (wait_clear),
    .mem_req   (mem_active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sticky fault flags; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_instr <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      if ((state == S_DECODE) && (state_next == S_TRAP)) begin
        illegal_instr <= 1'b1;
      end
      if (timeout) begin
        mem_fault <= 1'b1;
      end
    end
  end

  // Next-state and output decode; everything defaults to idle values
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_RS2;
    alu_op_sel    = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = MEM_TO_REG_ALU;
    instr_done    = 1'b0;

    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b0;
        alu_src_a = ALU_SRC_A_PC;
        alu_src_b = ALU_SRC_B_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_ALU;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        // old_pc + imm lands in alu_out as the branch/JAL target
        alu_src_a = ALU_SRC_A_OLD_PC;
        alu_src_b = ALU_SRC_B_IMM;
        if (is_jump_class(opcode) && !JUMP_EN) begin
          state_next = S_TRAP;
        end else begin
          case (opcode)
            OP_R:                 state_next = S_EXEC_R;
            OP_I:                 state_next = S_EXEC_I;
            OP_LOAD, OP_STORE:    state_next = S_MEM_ADDR;
            OP_BRANCH:            state_next = S_BRANCH;
            OP_JAL:               state_next = S_JAL;
            OP_JALR:              state_next = S_JALR;
            OP_LUI:               state_next = S_LUI;
            OP_AUIPC:             state_next = S_AUIPC;
            OP_FENCE, OP_SYSTEM: begin
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
            default:              state_next = S_TRAP;
          endcase
        end
      end

      S_EXEC_R: begin
        alu_src_a  = ALU_SRC_A_RS1;
        alu_src_b  = ALU_SRC_B_RS2;
        alu_op_sel = ALUOP_FUNCT;
        state_next = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_src_a  = ALU_SRC_A_RS1;
        alu_src_b  = ALU_SRC_B_IMM;
        alu_op_sel = ALUOP_FUNCT;
        state_next = S_WB_ALU;
      end

      S_LUI: begin
        alu_src_a  = ALU_SRC_A_ZERO;
        alu_src_b  = ALU_SRC_B_IMM;
        state_next = S_WB_ALU;
      end

      S_AUIPC: begin
        alu_src_a  = ALU_SRC_A_OLD_PC;
        alu_src_b  = ALU_SRC_B_IMM;
        state_next = S_WB_ALU;
      end

      S_MEM_ADDR: begin
        alu_src_a  = ALU_SRC_A_RS1;
        alu_src_b  = ALU_SRC_B_IMM;
        state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          state_next = S_WB_MEM;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end

      S_WB_ALU: begin
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_ALU;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_MEM;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = ALU_SRC_A_RS1;
        alu_src_b     = ALU_SRC_B_RS2;
        alu_op_sel    = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALU_OUT;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end

      S_JAL: begin
        // Register file captures the not-yet-updated PC (already PC+4)
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_PC;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALU_OUT;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_JALR: begin
        alu_src_a  = ALU_SRC_A_RS1;
        alu_src_b  = ALU_SRC_B_IMM;
        reg_write  = 1'b1;
        mem_to_reg = MEM_TO_REG_PC;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALU_LSB0;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: begin
        state_next = S_TRAP;
      end

      default: begin
        state_next = S_TRAP;
      end
    endcase
  end

  assign alu_op  = ALUOP_W'(alu_op_sel);
  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Self-checking bench for multicycle_control_unit. Instance 0 uses
//            default parameters, instance 1 has jumps disabled, instance 2
//            has MEM_TIMEOUT=4. All share clock and stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] AU = 7'b0010111;
  localparam logic [6:0] FN = 7'b0001111;
  localparam logic [6:0] SY = 7'b1110011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;

  wire [2:0] mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  wire [2:0] reg_write, instr_done, illegal_instr, mem_fault;
  wire [1:0] pc_src [3];
  wire [1:0] alu_src_a [3];
  wire [1:0] alu_src_b [3];
  wire [1:0] alu_op [3];
  wire [1:0] mem_to_reg [3];
  wire [3:0] state_o [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control_unit #(
      .ALUOP_W     (2),
      .ENABLE_JUMP ((g == 1) ? 0 : 1),
      .MEM_TIMEOUT ((g == 2) ? 4 : 0)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req[g]),
      .mem_we        (mem_we[g]),
      .i_or_d        (i_or_d[g]),
      .ir_write      (ir_write[g]),
      .pc_write      (pc_write[g]),
      .pc_write_cond (pc_write_cond[g]),
      .pc_src        (pc_src[g]),
      .alu_src_a     (alu_src_a[g]),
      .alu_src_b     (alu_src_b[g]),
      .alu_op        (alu_op[g]),
      .reg_write     (reg_write[g]),
      .mem_to_reg    (mem_to_reg[g]),
      .instr_done    (instr_done[g]),
      .illegal_instr (illegal_instr[g]),
      .mem_fault     (mem_fault[g]),
      .state_o       (state_o[g])
    );
  end

  int checks = 0;
  int fails  = 0;

  // Packed view: state, req, we, i_or_d, ir_write, pc_write, pc_write_cond,
  // pc_src, src_a, src_b, alu_op, reg_write, mem_to_reg, instr_done
  function automatic logic [21:0] mk(input logic [3:0] st, input logic req, we, iod, irw, pcw, pcwc,
                                     input logic [1:0] pcs, sa, sb, op, input logic rw,
                                     input logic [1:0] m2r, input logic done);
    return {st, req, we, iod, irw, pcw, pcwc, pcs, sa, sb, op, rw, m2r, done};
  endfunction

  function automatic logic [21:0] got(input int i);
    return {state_o[i], mem_req[i], mem_we[i], i_or_d[i], ir_write[i], pc_write[i],
            pc_write_cond[i], pc_src[i], alu_src_a[i], alu_src_b[i], alu_op[i],
            reg_write[i], mem_to_reg[i], instr_done[i]};
  endfunction

  task automatic check_vec(input string name, input int i, input logic [21:0] exp);
    logic [21:0] act;
    act = got(i);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: outputs got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input int i, input logic ill, input logic flt);
    checks++;
    if ({illegal_instr[i], mem_fault[i]} !== {ill, flt}) begin
      fails++;
      $display("FAIL %s dut%0d: illegal/fault got %b%b expected %b%b",
               name, i, illegal_instr[i], mem_fault[i], ill, flt);
    end
  endtask

  logic [21:0] e_idle, e_fetch, e_fwait, e_dec, e_dec_nop, e_exr, e_exi, e_maddr;
  logic [21:0] e_mrd, e_mwr_w, e_mwr, e_wba, e_wbm, e_br, e_jal, e_jalr, e_lui, e_aui, e_trap;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [6:0] op, input logic rdy, input logic [21:0] exp);
    vec_t v;
    v = '{op, rdy, exp};
    vecs.push_back(v);
  endtask

  // One clock cycle: inputs change on the falling edge, outputs sampled 1 later
  task automatic cycle(input logic [6:0] op, input logic rdy);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  // Assert reset for a cycle, check all instances, release; leaves DUTs in IDLE
  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_vec(name, i, e_idle);
      check_flags(name, i, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec({name, "_idle"}, 0, e_idle);
  endtask

  initial begin
    //             st   req we iod irw pcw pcwc pcs sa sb op  rw m2r done
    e_idle    = mk(4'd0,  0, 0, 0,  0,  0,  0,   0, 0, 0, 0,  0, 0,  0);
    e_fetch   = mk(4'd1,  1, 0, 0,  1,  1,  0,   0, 0, 1, 0,  0, 0,  0);
    e_fwait   = mk(4'd1,  1, 0, 0,  0,  0,  0,   0, 0, 1, 0,  0, 0,  0);
    e_dec     = mk(4'd2,  0, 0, 0,  0,  0,  0,   0, 3, 2, 0,  0, 0,  0);
    e_dec_nop = mk(4'd2,  0, 0, 0,  0,  0,  0,   0, 3, 2, 0,  0, 0,  1);
    e_exr     = mk(4'd3,  0, 0, 0,  0,  0,  0,   0, 1, 0, 2,  0, 0,  0);
    e_exi     = mk(4'd4,  0, 0, 0,  0,  0,  0,   0, 1, 2, 2,  0, 0,  0);
    e_maddr   = mk(4'd5,  0, 0, 0,  0,  0,  0,   0, 1, 2, 0,  0, 0,  0);
    e_mrd     = mk(4'd6,  1, 0, 1,  0,  0,  0,   0, 0, 0, 0,  0, 0,  0);
    e_mwr_w   = mk(4'd7,  1, 1, 1,  0,  0,  0,   0, 0, 0, 0,  0, 0,  0);
    e_mwr     = mk(4'd7,  1, 1, 1,  0,  0,  0,   0, 0, 0, 0,  0, 0,  1);
    e_wba     = mk(4'd8,  0, 0, 0,  0,  0,  0,   0, 0, 0, 0,  1, 0,  1);
    e_wbm     = mk(4'd9,  0, 0, 0,  0,  0,  0,   0, 0, 0, 0,  1, 1,  1);
    e_br      = mk(4'd10, 0, 0, 0,  0,  0,  1,   1, 1, 0, 1,  0, 0,  1);
    e_jal     = mk(4'd11, 0, 0, 0,  0,  1,  0,   1, 0, 0, 0,  1, 2,  1);
    e_jalr    = mk(4'd12, 0, 0, 0,  0,  1,  0,   2, 1, 2, 0,  1, 2,  1);
    e_lui     = mk(4'd13, 0, 0, 0,  0,  0,  0,   0, 2, 2, 0,  0, 0,  0);
    e_aui     = mk(4'd14, 0, 0, 0,  0,  0,  0,   0, 3, 2, 0,  0, 0,  0);
    e_trap    = mk(4'd15, 0, 0, 0,  0,  0,  0,   0, 0, 0, 0,  0, 0,  0);

    // Instruction stream for the default instance, one row per cycle from FETCH entry
    add(R, 1, e_fetch);  add(R, 1, e_dec);   add(R, 1, e_exr);   add(R, 1, e_wba);
    add(LD, 1, e_fetch); add(LD, 1, e_dec);  add(LD, 0, e_maddr);
    add(LD, 0, e_mrd);   add(LD, 0, e_mrd);  add(LD, 0, e_mrd);  add(LD, 1, e_mrd);
    add(LD, 1, e_wbm);
    add(BR, 1, e_fetch); add(BR, 1, e_dec);  add(BR, 1, e_br);
    add(ST, 1, e_fetch); add(ST, 1, e_dec);  add(ST, 0, e_maddr);
    add(ST, 0, e_mwr_w); add(ST, 1, e_mwr);
    add(JR, 1, e_fetch); add(JR, 1, e_dec);  add(JR, 1, e_jalr);
    add(JL, 1, e_fetch); add(JL, 1, e_dec);  add(JL, 1, e_jal);
    add(LU, 1, e_fetch); add(LU, 1, e_dec);  add(LU, 1, e_lui);  add(LU, 1, e_wba);
    add(AU, 1, e_fetch); add(AU, 1, e_dec);  add(AU, 1, e_aui);  add(AU, 1, e_wba);
    add(I, 1, e_fetch);  add(I, 1, e_dec);   add(I, 1, e_exi);   add(I, 1, e_wba);
    add(FN, 1, e_fetch); add(FN, 1, e_dec_nop);
    add(SY, 0, e_fwait); add(SY, 1, e_fetch); add(SY, 1, e_dec_nop);
    add(R, 0, e_fwait);

    do_reset("reset0");
    foreach (vecs[k]) begin
      cycle(vecs[k].op, vecs[k].rdy);
      check_vec($sformatf("vec%0d", k), 0, vecs[k].exp);
    end
    check_flags("stream_flags", 0, 1'b0, 1'b0);

    // Unknown opcode traps the default instance and stays there
    do_reset("reset_bad");
    cycle(BAD, 1); check_vec("bad_fetch", 0, e_fetch);
    cycle(BAD, 1); check_vec("bad_decode", 0, e_dec);
    cycle(BAD, 1); check_vec("bad_trap", 0, e_trap); check_flags("bad_flag", 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(R, 1);
      check_vec("bad_trap_hold", 0, e_trap);
    end
    check_flags("bad_flag_hold", 0, 1'b1, 1'b0);

    // Jumps disabled: JAL is illegal on instance 1, legal on instance 0
    do_reset("reset_nj");
    cycle(JL, 1); check_vec("nj_fetch", 1, e_fetch);
    cycle(JL, 1); check_vec("nj_decode", 1, e_dec);
    cycle(JL, 1); check_vec("nj_trap", 1, e_trap); check_vec("j_jal", 0, e_jal);
    check_flags("nj_flag", 1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(R, 1);
      check_vec("nj_trap_hold", 1, e_trap);
    end
    check_flags("nj_flag_hold", 1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_vec("nj_async_rst", 1, e_idle);
    check_flags("nj_async_rst_flags", 1, 1'b0, 1'b0);

    // Timeout: four stalled fetch cycles on instance 2 lead to TRAP
    do_reset("reset_to");
    for (int k = 0; k < 4; k++) begin
      cycle(R, 0);
      check_vec($sformatf("to_wait%0d", k), 2, e_fwait);
      check_flags("to_wait_flag", 2, 1'b0, 1'b0);
    end
    cycle(R, 0);
    check_vec("to_trap", 2, e_trap);
    check_flags("to_fault", 2, 1'b0, 1'b1);
    check_vec("to_disabled_wait", 0, e_fwait);
    cycle(R, 1);
    check_vec("to_trap_hold", 2, e_trap);
    check_flags("to_fault_hold", 2, 1'b0, 1'b1);

    // mem_ready on the limit cycle wins over the timeout
    do_reset("reset_to2");
    for (int k = 0; k < 3; k++) begin
      cycle(R, 0);
      check_vec("to2_wait", 2, e_fwait);
    end
    cycle(R, 1); check_vec("to2_ready", 2, e_fetch);
    cycle(R, 1); check_vec("to2_decode", 2, e_dec);
    check_flags("to2_no_fault", 2, 1'b0, 1'b0);

    // Reset in the middle of EXEC_I aborts immediately
    do_reset("reset_ex");
    cycle(I, 1); check_vec("ex_fetch", 0, e_fetch);
    cycle(I, 1); check_vec("ex_decode", 0, e_dec);
    cycle(I, 1); check_vec("ex_exec_i", 0, e_exi);
    #1 rst_n = 1'b0;
    #1;
    check_vec("ex_async_rst", 0, e_idle);
    check_flags("ex_async_rst_flags", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
